// File: rtl/timing_pkg.sv
// Shared timing constants: legacy modulus, count direction and clock-edge selection.
package timing_pkg;

    localparam int unsigned MAX_DEFAULT_LEGACY = 21;

    // Values of up_dn
    localparam bit COUNT_UP   = 1'b1;
    localparam bit COUNT_DOWN = 1'b0;

    // Values of NEG_EDGE
    localparam bit POSEDGE = 1'b0;
    localparam bit NEGEDGE = 1'b1;

endpackage : timing_pkg

// File: rtl/tick_prescaler.sv
// Clock prescaler: raises step on every PRESCALE-th enabled edge.
// Ports:
//   clk      - clock, active edge chosen by NEG_EDGE
//   reset_n  - synchronous active-low reset
//   clr      - synchronous clear of the prescaler count
//   enable   - advance the prescaler; low holds it
//   step     - combinational, high on the enabled edge that completes a period
module tick_prescaler
    import timing_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter bit          NEG_EDGE = NEGEDGE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic enable,
    output logic step
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;

    // Terminal prescaler value; PRESCALE=1 keeps pcnt at 0 so step follows enable
    assign step = enable && (pcnt == PW'(PRESCALE - 1));

    // Next prescaler value
    always_comb begin
        pcnt_n = pcnt;
        if (clr) begin
            pcnt_n = '0;
        end else if (enable) begin
            pcnt_n = step ? '0 : pcnt + PW'(1);
        end
    end

    // Prescaler register on the selected edge
    generate
        if (NEG_EDGE == NEGEDGE) begin : g_neg
            always_ff @(negedge clk) begin
                if (!reset_n) pcnt <= '0;
                else          pcnt <= pcnt_n;
            end
        end else begin : g_pos
            always_ff @(posedge clk) begin
                if (!reset_n) pcnt <= '0;
                else          pcnt <= pcnt_n;
            end
        end
    endgenerate

endmodule : tick_prescaler

// File: rtl/mod_counter_gen.sv
// Programmable modulo counter with up/down, prescaler, load/clear, tc pulse and sticky wrap flag.
// Ports:
//   clk, reset_n       - clock (edge chosen by NEG_EDGE), synchronous active-low reset
//   enable             - count enable; low holds count and prescaler
//   clear, load        - synchronous clear / parallel load of load_val
//   up_dn              - 1 up, 0 down
//   limit              - terminal value; 0 selects MAX_DEFAULT
//   count, tc, wrapped - registered count, one-cycle terminal pulse, sticky wrap flag
module mod_counter_gen
    import timing_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned MAX_DEFAULT = MAX_DEFAULT_LEGACY,
    parameter int unsigned PRESCALE    = 1,
    parameter bit          NEG_EDGE    = NEGEDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    logic             step;
    logic [WIDTH-1:0] eff_limit;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;
    logic             wrapped_n;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .NEG_EDGE (NEG_EDGE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear | load),
        .enable  (enable),
        .step    (step)
    );

    assign eff_limit = (limit == '0) ? WIDTH'(MAX_DEFAULT) : limit;

    // Next-state: clear > load > step > hold
    always_comb begin
        count_n   = count;
        tc_n      = 1'b0;
        wrapped_n = wrapped;
        if (clear) begin
            count_n   = '0;
            wrapped_n = 1'b0;
        end else if (load) begin
            count_n = load_val;
        end else if (step) begin
            if (up_dn == COUNT_UP) begin
                if (count < eff_limit) begin
                    count_n = count + WIDTH'(1);
                end else begin
                    // Out-of-range values land on 0 without a terminal pulse
                    count_n = '0;
                    tc_n    = (count == eff_limit);
                end
            end else begin
                if (count == '0) begin
                    count_n = eff_limit;
                    tc_n    = 1'b1;
                end else if (count > eff_limit) begin
                    count_n = eff_limit;
                end else begin
                    count_n = count - WIDTH'(1);
                end
            end
            if (tc_n) wrapped_n = 1'b1;
        end
    end

    // Output registers on the selected edge
    generate
        if (NEG_EDGE == NEGEDGE) begin : g_neg
            always_ff @(negedge clk) begin
                if (!reset_n) begin
                    count   <= '0;
                    tc      <= 1'b0;
                    wrapped <= 1'b0;
                end else begin
                    count   <= count_n;
                    tc      <= tc_n;
                    wrapped <= wrapped_n;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    count   <= '0;
                    tc      <= 1'b0;
                    wrapped <= 1'b0;
                end else begin
                    count   <= count_n;
                    tc      <= tc_n;
                    wrapped <= wrapped_n;
                end
            end
        end
    endgenerate

endmodule : mod_counter_gen

// File: tb/tb_mod_counter_gen.sv
// Directed bench: default-parameter counter on the falling edge plus a PRESCALE=3 rising-edge instance.
`timescale 1ns/1ps
module tb_mod_counter_gen;

    localparam int unsigned W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Falling-edge, PRESCALE=1 instance
    logic         reset_n = 1'b0, enable = 1'b0, clear = 1'b0, load = 1'b0, up_dn = 1'b1;
    logic [W-1:0] load_val = '0, limit = '0;
    logic [W-1:0] count;
    logic         tc, wrapped;

    // Rising-edge, PRESCALE=3 instance
    logic         p_reset_n = 1'b0, p_enable = 1'b0, p_clear = 1'b0, p_load = 1'b0, p_up_dn = 1'b1;
    logic [W-1:0] p_load_val = '0, p_limit = '0;
    logic [W-1:0] p_count;
    logic         p_tc, p_wrapped;

    int checks = 0;
    int errors = 0;

    mod_counter_gen #(.WIDTH(W), .MAX_DEFAULT(21), .PRESCALE(1), .NEG_EDGE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
        .load_val(load_val), .up_dn(up_dn), .limit(limit),
        .count(count), .tc(tc), .wrapped(wrapped)
    );

    mod_counter_gen #(.WIDTH(W), .MAX_DEFAULT(21), .PRESCALE(3), .NEG_EDGE(1'b0)) dut_p3 (
        .clk(clk), .reset_n(p_reset_n), .enable(p_enable), .clear(p_clear), .load(p_load),
        .load_val(p_load_val), .up_dn(p_up_dn), .limit(p_limit),
        .count(p_count), .tc(p_tc), .wrapped(p_wrapped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step_n();
        @(negedge clk);
        #1;
    endtask

    task automatic step_p();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string tag, input int c, input bit t, input bit w);
        check({tag, ".count"},   32'(count),   32'(c));
        check({tag, ".tc"},      32'(tc),      32'(t));
        check({tag, ".wrapped"}, 32'(wrapped), 32'(w));
    endtask

    initial begin
        // Reset
        step_n();
        step_n();
        expect_main("reset", 0, 1'b0, 1'b0);

        // Legacy sequence 0..21,0
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            step_n();
            expect_main($sformatf("legacy%0d", i), i, 1'b0, 1'b0);
        end
        step_n();
        expect_main("legacy_wrap", 0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step_n();
            expect_main($sformatf("legacy2_%0d", i), i, 1'b0, 1'b1);
        end

        // Enable low holds
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_n();
            expect_main($sformatf("hold%0d", i), 7, 1'b0, 1'b1);
        end
        enable = 1'b1;
        step_n();
        expect_main("resume", 8, 1'b0, 1'b1);

        // Clear drops count and wrapped
        clear = 1'b1;
        step_n();
        expect_main("clear", 0, 1'b0, 1'b0);
        clear = 1'b0;

        // Down count with limit 4 from a loaded 2
        limit = 5'd4; load = 1'b1; load_val = 5'd2;
        step_n();
        expect_main("dn_load", 2, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b0;
        step_n(); expect_main("dn1", 1, 1'b0, 1'b0);
        step_n(); expect_main("dn0", 0, 1'b0, 1'b0);
        step_n(); expect_main("dn_wrap", 4, 1'b1, 1'b1);
        step_n(); expect_main("dn3", 3, 1'b0, 1'b1);
        clear = 1'b1;
        step_n(); expect_main("dn_clear", 0, 1'b0, 1'b0);
        clear = 1'b0;

        // Out of range, up: 9 with limit 5 -> 0, no tc
        up_dn = 1'b1; limit = 5'd21; load = 1'b1; load_val = 5'd9;
        step_n(); expect_main("oor_up_load", 9, 1'b0, 1'b0);
        load = 1'b0; limit = 5'd5;
        step_n(); expect_main("oor_up", 0, 1'b0, 1'b0);

        // Out of range, down: 31 with limit 5 -> 5, no tc
        up_dn = 1'b0; load = 1'b1; load_val = 5'd31;
        step_n(); expect_main("oor_dn_load", 31, 1'b0, 1'b0);
        load = 1'b0;
        step_n(); expect_main("oor_dn", 5, 1'b0, 1'b0);
        step_n(); expect_main("oor_dn_next", 4, 1'b0, 1'b0);

        // Full-range limit wraps at all-ones
        limit = 5'd31; up_dn = 1'b1; load = 1'b1; load_val = 5'd30;
        step_n(); expect_main("max_load", 30, 1'b0, 1'b0);
        load = 1'b0;
        step_n(); expect_main("max31", 31, 1'b0, 1'b0);
        step_n(); expect_main("max_wrap", 0, 1'b1, 1'b1);

        // Load leaves wrapped set
        load = 1'b1; load_val = 5'd10;
        step_n(); expect_main("load_keep_wrap", 10, 1'b0, 1'b1);

        // Reset beats clear/load/enable
        reset_n = 1'b0; clear = 1'b1; load_val = 5'd3;
        step_n(); expect_main("prio_reset", 0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step_n(); expect_main("prio_clear", 0, 1'b0, 1'b0);
        clear = 1'b0;
        step_n(); expect_main("prio_load", 3, 1'b0, 1'b0);
        load = 1'b0;
        step_n(); expect_main("after_load", 4, 1'b0, 1'b0);

        // PRESCALE=3, rising edge, limit 2
        step_p();
        check("p_reset.count", 32'(p_count), 32'd0);
        check("p_reset.wrapped", 32'(p_wrapped), 32'd0);
        p_reset_n = 1'b1; p_enable = 1'b1; p_limit = 5'd2; p_up_dn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step_p();
            check($sformatf("p_seq%0d.count", k), 32'(p_count), 32'(k / 3 % 3));
            check($sformatf("p_seq%0d.tc", k), 32'(p_tc), (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("p_seq%0d.wrapped", k), 32'(p_wrapped), (k == 9) ? 32'd1 : 32'd0);
        end
        step_p();
        check("p_after_tc.tc", 32'(p_tc), 32'd0);
        // Prescaler at 1 holds while disabled
        p_enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step_p();
            check($sformatf("p_hold%0d.count", k), 32'(p_count), 32'd0);
        end
        p_enable = 1'b1;
        step_p(); check("p_resume_mid.count", 32'(p_count), 32'd0);
        step_p(); check("p_resume_step.count", 32'(p_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_counter_gen

// File: doc/mod_counter_gen.md
Name: mod_counter_gen

Overview:
Parametrised modulo counter. It is the next generation of the fixed 0..21 enable-cleared timing counter used in the display/timing path.
- Adds width and default-modulus parameters, a runtime limit, up/down counting, and a clock prescaler.
- Adds synchronous clear and parallel load, a terminal-count pulse and a sticky wrap flag.
- Feeds timing and sequencing logic that needs a programmable cycle count on either clock edge.

Parameters:
WIDTH, 5, bit width of count, limit and load_val.
MAX_DEFAULT, 21, limit value used when the limit input is 0 (reproduces the legacy 0..21 sequence).
PRESCALE, 1, number of enabled clock cycles per count step (1 = step every enabled cycle); legal range 1..2^16-1.
NEG_EDGE, 1, 1 = all state updates on falling clk edge, 0 = on rising edge.

Ports:
clk  in  1  system clock; active edge selected by NEG_EDGE.
reset_n  in  1  synchronous, active-low reset, sampled on the active clk edge.
enable  in  1  count enable; low = hold (not clear).
clear  in  1  synchronous clear of count, prescaler, tc and wrapped.
load  in  1  synchronous parallel load of load_val.
load_val  in  WIDTH  value loaded when load=1.
up_dn  in  1  1 = count up, 0 = count down.
limit  in  WIDTH  terminal value; count range is 0..eff_limit, eff_limit = (limit==0) ? MAX_DEFAULT : limit.
count  out  WIDTH  registered counter value.
tc  out  1  registered terminal-count pulse, one clk cycle wide.
wrapped  out  1  sticky flag: set on any tc, cleared by reset or clear.

Behaviour:
- All registers update only on the active edge; no combinational path from any input to an output.
- Reset (reset_n=0 at active edge): count=0, tc=0, wrapped=0, prescaler=0.
- Priority per edge: reset_n low > clear > load > (enable & step) > hold.
- clear=1: count=0, prescaler=0, tc=0, wrapped=0.
- load=1: count=load_val, prescaler=0, tc=0; wrapped unchanged.
- Prescaler:
  - Advances only when enable=1 and no clear/load.
  - step=1 when prescaler==PRESCALE-1; on that edge the prescaler returns to 0.
  - PRESCALE=1 gives step=1 on every enabled edge.
  - enable=0 holds the prescaler value.
- Count step, up (up_dn=1):
  - count<eff_limit: count+1, tc=0.
  - count==eff_limit: count=0, tc=1.
  - count>eff_limit (out of range after a limit change or load): count=0, tc=0.
- Count step, down (up_dn=0):
  - count==0: count=eff_limit, tc=1.
  - count>eff_limit: count=eff_limit, tc=0.
  - otherwise: count-1, tc=0.
- Any edge without a step: tc=0 and count holds. This includes enable=0 and prescaler mid-period.
- tc is high in the same cycle the wrapped count value (0 up / eff_limit down) first appears on count.
- wrapped is set on the edge where tc is set.
- limit and up_dn are sampled on each step edge. Changing them mid-count takes effect at the next step, with no glitch.
- eff_limit = 2^WIDTH-1: up-count wraps naturally at all-ones, tc asserts at all-ones→0.
- load_val > eff_limit is loaded as-is and corrected by the out-of-range rule on the next step.
- reset_n low while clear/load/enable are high: reset wins, outputs return to reset values next edge.

Decomposition:
- Shared package (timing_pkg): MAX_DEFAULT_LEGACY=21 constant, COUNT_UP/COUNT_DOWN constants for up_dn, edge-select constants POSEDGE=0/NEGEDGE=1.
- One sub-module, tick_prescaler:
  - Parameters PRESCALE, NEG_EDGE; ports clk, reset_n, clr, enable, step.
  - Counter width is $clog2(PRESCALE), minimum 1.
  - The top module drives clr = clear|load.
- Edge selection is one generate branch per module; there is no clock inversion logic outside the generate.

Test Plan:
- Legacy mode (limit=0, PRESCALE=1, up, enable=1 after reset) -> count 0,1,...,21,0; tc=1 exactly on the edge count becomes 0 after 21; wrapped=1 afterwards.
- enable dropped at count=7 for 5 cycles -> count holds 7, tc=0; resumes 8 on first enabled edge (contrast: legacy cleared).
- Down count, limit=4, load_val=2 loaded -> 2,1,0,4 with tc=1 on the 4, then 3,2...; clear at count=3 -> count=0, wrapped=0 next edge.
- PRESCALE=3, limit=2, up -> count changes every 3rd enabled edge: 0,0,0,1,1,1,2,2,2,0; tc high for one cycle only.
- Out-of-range: count=9, change limit to 5 (up) -> next step count=0, tc=0; load_val=31 with limit=5 (down) -> next step count=5, tc=0.
- Priority: reset_n=0 with clear=1, load=1, load_val=3 at count=10 -> count=0, tc=0; then load=1 and clear=1 together -> count=0 (clear wins).
